// File: rtl/slave_tx_port_arbiter_if.sv
// Bundle of the three requester ports and the shared SIE transmit port.
// The master modport is the requester/SIE side; the slave modport is the arbiter.
interface slave_tx_port_arbiter_if;
    logic       req0Req,  req1Req,  req2Req;
    logic       req0WEn,  req1WEn,  req2WEn;
    logic [7:0] req0Data, req1Data, req2Data;
    logic [7:0] req0Cntl, req1Cntl, req2Cntl;
    logic       req0Gnt,  req1Gnt,  req2Gnt;
    logic       req0Rdy,  req1Rdy,  req2Rdy;
    logic       SCTxPortRdy;
    logic       SCTxPortWEn;
    logic [7:0] SCTxPortData;
    logic [7:0] SCTxPortCntl;

    modport master (
        output req0Req, req1Req, req2Req,
        output req0WEn, req1WEn, req2WEn,
        output req0Data, req1Data, req2Data,
        output req0Cntl, req1Cntl, req2Cntl,
        output SCTxPortRdy,
        input  req0Gnt, req1Gnt, req2Gnt,
        input  req0Rdy, req1Rdy, req2Rdy,
        input  SCTxPortWEn, SCTxPortData, SCTxPortCntl
    );

    modport slave (
        input  req0Req, req1Req, req2Req,
        input  req0WEn, req1WEn, req2WEn,
        input  req0Data, req1Data, req2Data,
        input  req0Cntl, req1Cntl, req2Cntl,
        input  SCTxPortRdy,
        output req0Gnt, req1Gnt, req2Gnt,
        output req0Rdy, req1Rdy, req2Rdy,
        output SCTxPortWEn, SCTxPortData, SCTxPortCntl
    );
endinterface

// File: rtl/slave_tx_port_arbiter.sv
// Round-robin arbiter sharing the SIE transmit port between three requesters.
// One owner at a time, no preemption; the owner's write signals are muxed to
// the SIE and SIE ready is returned only to the owner.
module slave_tx_port_arbiter (
    input  logic                          clk,
    input  logic                          rst,
    slave_tx_port_arbiter_if.slave        bus
);
    typedef enum logic {IDLE, GRANTED} state_t;

    state_t     state_q;
    logic [1:0] owner_q;
    logic [1:0] last_q;
    logic [2:0] gnt_q;

    // Index 3 is padding so an illegal owner reads as "no request, no write".
    logic [3:0] req_vec;
    logic [3:0] wen_vec;
    logic [1:0] cand1, cand2, cand3;
    logic [1:0] pick_d;
    logic       any_req;

    logic       wen_mux;
    logic [7:0] data_mux;
    logic [7:0] cntl_mux;

    // Modulo-3 increment; an illegal 3 wraps to 0 so candidates stay legal.
    function automatic logic [1:0] inc3(input logic [1:0] x);
        return (x >= 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    assign req_vec = {1'b0, bus.req2Req, bus.req1Req, bus.req0Req};
    assign wen_vec = {1'b0, bus.req2WEn, bus.req1WEn, bus.req0WEn};
    assign any_req = |req_vec;

    // Search order starts just after the last owner, ending on the last owner.
    assign cand1 = inc3(last_q);
    assign cand2 = inc3(cand1);
    assign cand3 = inc3(cand2);

    // Round-robin pick among the currently raised requests.
    always_comb begin
        pick_d = cand3;
        if (req_vec[cand1]) begin
            pick_d = cand1;
        end else if (req_vec[cand2]) begin
            pick_d = cand2;
        end
    end

    // Arbitration FSM with registered grants; grants hold until the owner drops Req.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            last_q  <= 2'd2;
            gnt_q   <= 3'b000;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q <= GRANTED;
                        owner_q <= pick_d;
                        last_q  <= pick_d;
                        gnt_q   <= 3'b001 << pick_d;
                    end
                end
                GRANTED: begin
                    if (!req_vec[owner_q]) begin
                        state_q <= IDLE;
                        gnt_q   <= 3'b000;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 3'b000;
                end
            endcase
        end
    end

    // Zero-latency mux of the owner's write signals; quiet bus when idle.
    always_comb begin
        wen_mux  = 1'b0;
        data_mux = 8'h00;
        cntl_mux = 8'h00;
        if (state_q == GRANTED) begin
            case (owner_q)
                2'd0: begin
                    wen_mux  = wen_vec[0];
                    data_mux = bus.req0Data;
                    cntl_mux = bus.req0Cntl;
                end
                2'd1: begin
                    wen_mux  = wen_vec[1];
                    data_mux = bus.req1Data;
                    cntl_mux = bus.req1Cntl;
                end
                2'd2: begin
                    wen_mux  = wen_vec[2];
                    data_mux = bus.req2Data;
                    cntl_mux = bus.req2Cntl;
                end
                default: begin
                    wen_mux  = 1'b0;
                    data_mux = 8'h00;
                    cntl_mux = 8'h00;
                end
            endcase
        end
    end

    assign bus.SCTxPortWEn  = wen_mux;
    assign bus.SCTxPortData = data_mux;
    assign bus.SCTxPortCntl = cntl_mux;

    assign bus.req0Gnt = gnt_q[0];
    assign bus.req1Gnt = gnt_q[1];
    assign bus.req2Gnt = gnt_q[2];

    assign bus.req0Rdy = bus.SCTxPortRdy & gnt_q[0];
    assign bus.req1Rdy = bus.SCTxPortRdy & gnt_q[1];
    assign bus.req2Rdy = bus.SCTxPortRdy & gnt_q[2];
endmodule

// File: doc/slave_tx_port_arbiter.md
# slave_tx_port_arbiter

Round-robin arbiter that shares the slave controller's single SIE transmit port (SCTxPort) between three requesters: packet send, direct line-state control and a spare/test source. Each requester drives its own Req/WEn/Data/Cntl set and receives its own Gnt/Rdy. The arbiter grants one owner at a time, muxes the owner's write signals onto the SIE port and gates the SIE's ready back to the owner only. It sits between the slave-side transmit sources and the SIE transmit path.

## Interface

- No parameters; requester count fixed at 3, data and control width fixed at 8.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req0Req / req1Req / req2Req  in  1 each  requester holds high for the whole transaction
- req0WEn / req1WEn / req2WEn  in  1 each  requester write strobe
- req0Data / req1Data / req2Data  in  8 each  requester data byte
- req0Cntl / req1Cntl / req2Cntl  in  8 each  requester control byte
- req0Gnt / req1Gnt / req2Gnt  out  1 each  registered grant, at most one high
- req0Rdy / req1Rdy / req2Rdy  out  1 each  SCTxPortRdy gated by that requester's grant
- SCTxPortRdy  in  1  SIE ready to accept a write
- SCTxPortWEn  out  1  muxed write strobe to SIE
- SCTxPortData  out  8  muxed data to SIE
- SCTxPortCntl  out  8  muxed control to SIE

## Operation

- State machine: IDLE, GRANTED. Registers: state, owner[1:0], last[1:0], three grant flops.
- Reset (rst low, asynchronous): state=IDLE, all Gnt=0, last=2 (requester 0 has top priority first), owner=0. Outputs: SCTxPortWEn=0, SCTxPortData=8'h00, SCTxPortCntl=8'h00, all reqNRdy=0.
- IDLE: if any Req high, pick first high Req searching last+1, last+2, last (mod 3); next edge: state=GRANTED, owner=pick, last=pick, Gnt[pick]=1. No Req: stay, no change.
- GRANTED: while Req[owner] high, stay; Req of other requesters ignored (no preemption). When Req[owner] low at an edge: state=IDLE, Gnt[owner]=0; last keeps owner.
- Mux (combinational from registered owner/state): in GRANTED, SCTxPortWEn=WEn[owner]; Data/Cntl=owner's values. In IDLE: WEn=0, Data=Cntl=8'h00 regardless of inputs.
- reqNRdy = SCTxPortRdy & reqNGnt; non-owners always see 0.
- WEn from a non-owner never reaches the SIE; WEn from the owner in the same cycle its Req drops is still forwarded (grant still high that cycle).
- Owner index 3 is illegal; unreachable; if forced, treated as IDLE outputs.

## Timing

- Grant latency: Req high sampled at edge k (from IDLE) -> Gnt high after edge k.
- Release: Req[owner] low sampled at edge m -> Gnt low after edge m; IDLE for one full cycle; next grant earliest after edge m+1. Minimum one-cycle bus gap between owners.
- Back-to-back same requester: drop Req for one cycle, re-raise -> re-granted after one IDLE cycle, but only if no other Req is pending (round-robin moves past it).
- Simultaneous Reqs in IDLE: round-robin order above; all three high continuously, each releasing after one write -> grant order 0,1,2,0,...
- Mux and Rdy gating are zero-latency (same cycle as inputs).
- Reset asserted mid-transaction: grants, WEn, Data, Cntl drop to reset values immediately (asynchronous), no edge required; after release, arbitration restarts with requester 0 priority.

## Test plan

- Reset: hold rst low with all Req=1, WEn=1, Data=8'hA5 -> all Gnt=0, SCTxPortWEn=0, Data=Cntl=8'h00; release rst -> req0Gnt=1 after first edge.
- Single owner: req1Req=1, SCTxPortRdy=1, req1WEn pulse with Data=8'h02, Cntl=8'h00 -> req1Gnt after 1 edge, req1Rdy=1, req0Rdy=req2Rdy=0, SIE sees WEn=1, Data=8'h02.
- Non-owner isolation: req0 granted, req2WEn=1 Data=8'h55 Cntl=8'h05 -> SIE WEn follows req0WEn only, Data/Cntl equal req0 values.
- Round-robin: all three Req held, each drops Req one cycle after grant -> grant sequence 0,1,2,0 with exactly one IDLE cycle between grants.
- No preemption: req2 granted, req0Req rises -> req2Gnt stays until req2Req drops; req0Gnt rises one IDLE cycle later.
- Async reset mid-grant: req1 granted with WEn=1, pull rst low between edges -> req1Gnt and SCTxPortWEn go 0 before next edge.
